mem_load_ctrl: RTL and testbench

Parametrised memory-port controller between the processor core, the IRAM/DRAM blocks and an external loader. It replaces single-word external IRAM writes with burst loading into either memory. Loads use a valid/ready handshake, an auto-incrementing address, a word count and a checksum. A small mode FSM (IDLE/LOAD/RUN/HALTED) grants memory ports to either the loader or the core and gates the core start.

---
 rtl/mem_load_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_load_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_ctrl.sv
// Memory-port controller: burst loader into IRAM/DRAM plus core run/halt
// gating. A four-state mode FSM decides who owns the memory ports.
module mem_load_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic              i_clock,
    input  logic              i_reset,
    // loader command
    input  logic              i_load_req,
    input  logic              i_ld_sel,
    input  logic [ADDR_W-1:0] i_ld_base,
    input  logic [LEN_W-1:0]  i_ld_len,
    // loader stream
    input  logic              i_ext_valid,
    input  logic [DATA_W-1:0] i_ext_data,
    output logic              o_ext_ready,
    // core interface
    input  logic              i_run_req,
    input  logic              i_core_halt,
    input  logic [ADDR_W-1:0] i_core_iram_addr,
    input  logic              i_core_iram_re,
    input  logic [ADDR_W-1:0] i_core_dram_addr,
    input  logic              i_core_dram_re,
    input  logic              i_core_dram_we,
    input  logic [DATA_W-1:0] i_core_dram_wdata,
    output logic              o_core_start,
    // IRAM port
    output logic [ADDR_W-1:0] o_iram_addr,
    output logic              o_iram_we,
    output logic              o_iram_re,
    output logic [DATA_W-1:0] o_iram_wdata,
    // DRAM port
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic              o_dram_we,
    output logic              o_dram_re,
    output logic [DATA_W-1:0] o_dram_wdata,
    // status
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [DATA_W-1:0] o_checksum,
    output logic              o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALTED} state_t;

    state_t              r_state, w_next;
    logic                r_sel;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_load_done;
    logic                r_load_err;
    // registered loader write, presented on the memory port one cycle after the beat
    logic                r_wr_iram;
    logic                r_wr_dram;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    logic w_cmd_ok;
    logic w_beat;
    logic w_last;
    logic w_ld_ok;
    logic w_ld_bad;

    // IDLE and HALTED are the only states that accept commands
    assign w_cmd_ok = (r_state == S_IDLE) || (r_state == S_HALTED);
    assign w_ld_ok  = w_cmd_ok && i_load_req && (i_ld_len != '0);
    assign w_ld_bad = w_cmd_ok && i_load_req && (i_ld_len == '0);
    assign w_beat   = (r_state == S_LOAD) && i_ext_valid;
    assign w_last   = w_beat && (r_count == r_len - LEN_W'(1));

    // next-state and port muxing; loader path is registered, core path is combinational
    always_comb begin
        w_next       = r_state;
        o_ext_ready  = 1'b0;
        o_core_start = 1'b0;
        o_busy       = 1'b0;
        o_iram_addr  = r_wr_addr;
        o_iram_we    = r_wr_iram;
        o_iram_re    = 1'b0;
        o_iram_wdata = r_wr_data;
        o_dram_addr  = r_wr_addr;
        o_dram_we    = r_wr_dram;
        o_dram_re    = 1'b0;
        o_dram_wdata = r_wr_data;
        case (r_state)
            S_IDLE, S_HALTED: begin
                // load beats run: a load request takes priority over run_req
                if (w_ld_ok)
                    w_next = S_LOAD;
                else if (!i_load_req && i_run_req)
                    w_next = S_RUN;
            end
            S_LOAD: begin
                o_ext_ready = 1'b1;
                o_busy      = 1'b1;
                if (w_last)
                    w_next = S_IDLE;
            end
            S_RUN: begin
                o_core_start = 1'b1;
                o_busy       = 1'b1;
                o_iram_addr  = i_core_iram_addr;
                o_iram_we    = 1'b0;
                o_iram_re    = i_core_iram_re;
                o_iram_wdata = '0;
                o_dram_addr  = i_core_dram_addr;
                o_dram_we    = i_core_dram_we;
                o_dram_re    = i_core_dram_re;
                o_dram_wdata = i_core_dram_wdata;
                if (i_core_halt)
                    w_next = S_HALTED;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // mode state register
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // burst bookkeeping, registered write and status pulses
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sel       <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_checksum  <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_wr_iram   <= 1'b0;
            r_wr_dram   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_load_done <= w_last;
            r_load_err  <= w_ld_bad;
            r_wr_iram   <= w_beat && !r_sel;
            r_wr_dram   <= w_beat && r_sel;
            if (w_ld_ok) begin
                r_sel      <= i_ld_sel;
                r_base     <= i_ld_base;
                r_len      <= i_ld_len;
                r_count    <= '0;
                r_checksum <= '0;
            end
            if (w_beat) begin
                // address adder is ADDR_W wide, carry dropped so bursts wrap
                r_wr_addr  <= r_base + ADDR_W'(r_count);
                r_wr_data  <= i_ext_data;
                r_count    <= r_count + LEN_W'(1);
                r_checksum <= r_checksum + i_ext_data;
            end
        end
    end

    assign o_load_done = r_load_done;
    assign o_load_err  = r_load_err;
    assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl: bursts, wrap, gaps, zero length,
// run/halt/resume, command collision and reset mid-burst.
module tb_mem_load_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req, ld_sel;
    logic [ADDR_W-1:0] ld_base;
    logic [LEN_W-1:0]  ld_len;
    logic              ext_valid;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ready;
    logic              run_req, core_halt;
    logic [ADDR_W-1:0] core_iram_addr, core_dram_addr;
    logic              core_iram_re, core_dram_re, core_dram_we;
    logic [DATA_W-1:0] core_dram_wdata;
    logic              core_start;
    logic [ADDR_W-1:0] iram_addr, dram_addr;
    logic              iram_we, iram_re, dram_we, dram_re;
    logic [DATA_W-1:0] iram_wdata, dram_wdata;
    logic              load_done, load_err, busy;
    logic [DATA_W-1:0] checksum;

    int n_chk  = 0;
    int n_fail = 0;

    mem_load_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_load_req(load_req), .i_ld_sel(ld_sel), .i_ld_base(ld_base), .i_ld_len(ld_len),
        .i_ext_valid(ext_valid), .i_ext_data(ext_data), .o_ext_ready(ext_ready),
        .i_run_req(run_req), .i_core_halt(core_halt),
        .i_core_iram_addr(core_iram_addr), .i_core_iram_re(core_iram_re),
        .i_core_dram_addr(core_dram_addr), .i_core_dram_re(core_dram_re),
        .i_core_dram_we(core_dram_we), .i_core_dram_wdata(core_dram_wdata),
        .o_core_start(core_start),
        .o_iram_addr(iram_addr), .o_iram_we(iram_we), .o_iram_re(iram_re), .o_iram_wdata(iram_wdata),
        .o_dram_addr(dram_addr), .o_dram_we(dram_we), .o_dram_re(dram_re), .o_dram_wdata(dram_wdata),
        .o_load_done(load_done), .o_load_err(load_err), .o_checksum(checksum), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // advance one clock; outputs are then sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic sel, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        load_req = 1'b1; ld_sel = sel; ld_base = base; ld_len = len;
        tick();
        load_req = 1'b0;
    endtask

    logic [DATA_W-1:0] w4 [4];
    logic [ADDR_W-1:0] wa3 [3];
    logic [DATA_W-1:0] wd3 [3];
    logic              vpat [5];

    initial begin
        int k;
        w4  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        wa3 = '{9'h1FE, 9'h1FF, 9'h000};
        wd3 = '{16'h8001, 16'h8002, 16'h0004};
        vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; load_req = 0; ld_sel = 0; ld_base = '0; ld_len = '0;
        ext_valid = 0; ext_data = '0; run_req = 0; core_halt = 0;
        core_iram_addr = '0; core_iram_re = 0; core_dram_addr = '0;
        core_dram_re = 0; core_dram_we = 0; core_dram_wdata = '0;
        tick(); tick();
        chk("rst_ready", ext_ready, 0);
        chk("rst_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", {iram_we, iram_re, dram_we, dram_re}, 0);
        chk("rst_addr", {iram_addr, dram_addr}, 0);
        chk("rst_csum", checksum, 0);
        chk("rst_pulses", {load_done, load_err}, 0);
        rst = 1'b0;

        // IRAM burst, back-to-back beats
        start_load(1'b0, 9'h010, 10'd4);
        chk("t1_ready", ext_ready, 1);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            ext_valid = 1'b1; ext_data = w4[i];
            tick();
            chk("t1_iwe", iram_we, 1);
            chk("t1_iaddr", iram_addr, 32'h010 + i);
            chk("t1_idata", iram_wdata, w4[i]);
            chk("t1_dwe", dram_we, 0);
            chk("t1_done", load_done, (i == 3) ? 1 : 0);
        end
        ext_valid = 1'b0;
        chk("t1_ready_low", ext_ready, 0);
        chk("t1_csum", checksum, 16'hAAAA);
        tick();
        chk("t1_iwe_off", iram_we, 0);
        chk("t1_done_off", load_done, 0);
        chk("t1_idle", busy, 0);

        // DRAM burst with wrap and gaps
        start_load(1'b1, 9'h1FE, 10'd3);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            ext_valid = vpat[i];
            ext_data  = vpat[i] ? wd3[k] : 16'hDEAD;
            tick();
            chk("t2_dwe", dram_we, vpat[i]);
            chk("t2_iwe", iram_we, 0);
            if (vpat[i]) begin
                chk("t2_daddr", dram_addr, wa3[k]);
                chk("t2_ddata", dram_wdata, wd3[k]);
                k++;
            end
            chk("t2_ready", ext_ready, (i == 4) ? 0 : 1);
        end
        ext_valid = 1'b0;
        chk("t2_done", load_done, 1);
        chk("t2_csum", checksum, 16'h0007);
        tick();

        // zero-length request is rejected
        start_load(1'b0, 9'h000, 10'd0);
        chk("t3_err", load_err, 1);
        chk("t3_ready", ext_ready, 0);
        chk("t3_busy", busy, 0);
        chk("t3_csum", checksum, 16'h0007);
        tick();
        chk("t3_err_off", load_err, 0);

        // run, pass-through, halt, resume
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("t4_start", core_start, 1);
        chk("t4_busy", busy, 1);
        core_dram_we = 1'b1; core_dram_addr = 9'h005; core_dram_wdata = 16'hBEEF;
        core_iram_addr = 9'h033; core_iram_re = 1'b1;
        #1;
        chk("t4_dwe", dram_we, 1);
        chk("t4_daddr", dram_addr, 9'h005);
        chk("t4_ddata", dram_wdata, 16'hBEEF);
        chk("t4_iaddr", iram_addr, 9'h033);
        chk("t4_ire", iram_re, 1);
        chk("t4_iwe", iram_we, 0);
        core_halt = 1'b1; tick(); core_halt = 1'b0;
        chk("t4_halt_start", core_start, 0);
        chk("t4_halt_dwe", dram_we, 0);
        chk("t4_halt_ire", iram_re, 0);
        chk("t4_halt_busy", busy, 0);
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("t4_resume", core_start, 1);
        core_halt = 1'b1; tick(); core_halt = 1'b0;
        chk("t4_halt2", core_start, 0);
        core_dram_we = 0; core_iram_re = 0;

        // load and run together from HALTED: load wins
        run_req = 1'b1;
        start_load(1'b0, 9'h020, 10'd2);
        chk("t5_ready", ext_ready, 1);
        chk("t5_start", core_start, 0);
        tick();
        run_req = 1'b0;
        chk("t5_ign_run", core_start, 0);
        chk("t5_still_load", ext_ready, 1);
        ext_valid = 1'b1; ext_data = 16'h0100; tick();
        chk("t5_iaddr0", iram_addr, 9'h020);
        ext_data = 16'h0200; tick();
        ext_valid = 1'b0;
        chk("t5_iaddr1", iram_addr, 9'h021);
        chk("t5_done", load_done, 1);
        chk("t5_csum", checksum, 16'h0300);
        tick();

        // reset in the middle of a burst
        start_load(1'b1, 9'h040, 10'd8);
        for (int i = 0; i < 3; i++) begin
            ext_valid = 1'b1; ext_data = DATA_W'(i + 1); tick();
            chk("t6_daddr", dram_addr, 32'h040 + i);
        end
        rst = 1'b1; ext_data = 16'h0004; tick();
        chk("t6_dwe", dram_we, 0);
        chk("t6_ready", ext_ready, 0);
        chk("t6_done", load_done, 0);
        chk("t6_csum", checksum, 0);
        chk("t6_busy", busy, 0);
        chk("t6_daddr_rst", dram_addr, 0);
        rst = 1'b0; ext_valid = 1'b0;
        tick();
        chk("t6_no_write", dram_we, 0);
        start_load(1'b0, 9'h050, 10'd1);
        chk("t6_reload", ext_ready, 1);
        ext_valid = 1'b1; ext_data = 16'h5555; tick();
        ext_valid = 1'b0;
        chk("t6_iwe", iram_we, 1);
        chk("t6_iaddr", iram_addr, 9'h050);
        chk("t6_done2", load_done, 1);
        chk("t6_csum2", checksum, 16'h5555);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
